// File: rtl/mxu_axil_regs.sv
// AXI4-Lite slave for the matrix unit: control/status registers plus two byte operand buffers.
module mxu_axil_regs #(
    parameter int unsigned SIZE      = 16,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_BASE = 32'h0100
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [ADDR_W-1:0]              awaddr,
    input  logic                           awvalid,
    output logic                           awready,
    input  logic [31:0]                    wdata,
    input  logic [3:0]                     wstrb,
    input  logic                           wvalid,
    output logic                           wready,
    output logic [1:0]                     bresp,
    output logic                           bvalid,
    input  logic                           bready,
    input  logic [ADDR_W-1:0]              araddr,
    input  logic                           arvalid,
    output logic                           arready,
    output logic [31:0]                    rdata,
    output logic [1:0]                     rresp,
    output logic                           rvalid,
    input  logic                           rready,
    output logic                           start,
    input  logic                           done,
    input  logic                           busy,
    output logic [7:0]                     cycles,
    output logic                           memsel,
    input  logic [$clog2(2*SIZE*SIZE)-1:0] buf_raddr,
    output logic [7:0]                     buf_rdata
);

    localparam int unsigned BufBytes = 2 * SIZE * SIZE;
    localparam int unsigned BufAw    = $clog2(BufBytes);

    localparam logic [ADDR_W-1:0] AddrCtrl   = '0;
    localparam logic [ADDR_W-1:0] AddrCycles = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] AddrMemsel = ADDR_W'(8);
    localparam logic [ADDR_W-1:0] AddrBase   = ADDR_W'(DATA_BASE);
    localparam logic [ADDR_W-1:0] AddrSpan   = ADDR_W'(BufBytes);
    localparam logic [ADDR_W-1:0] WordMask   = ~ADDR_W'(3);

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;

    typedef enum logic [1:0] {WIdle, WHaveAw, WHaveW, WResp} w_state_e;
    typedef enum logic {RIdle, RResp} r_state_e;

    w_state_e          w_state_q, w_state_d;
    r_state_e          r_state_q, r_state_d;
    logic [ADDR_W-1:0] awaddr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic [1:0]        bresp_q, rresp_q;
    logic [31:0]       rdata_q;
    logic [7:0]        cycles_q;
    logic              memsel_q, done_q, start_q;
    logic [7:0]        buf_rdata_q;
    logic [7:0]        mem_q [BufBytes];

    logic              aw_fire, w_fire, ar_fire, aw_have, w_have, commit;
    logic [ADDR_W-1:0] wr_addr, wr_word, wr_off, rd_word, rd_off;
    logic [31:0]       wr_data, rd_value;
    logic [3:0]        wr_strb;
    logic              wr_data_hit, wr_reg_hit, wr_ok, rd_data_hit, rd_ok;
    logic              mem_we, start_d;
    logic [BufAw-1:0]  wr_idx, rd_idx;

    assign awready = (w_state_q == WIdle) || (w_state_q == WHaveW);
    assign wready  = (w_state_q == WIdle) || (w_state_q == WHaveAw);
    // A completing read frees the slot, so a new AR can land in the same cycle.
    assign arready = (r_state_q == RIdle) || rready;
    assign aw_fire = awvalid && awready;
    assign w_fire  = wvalid && wready;
    assign ar_fire = arvalid && arready;

    // Commit as soon as both halves are available, taking whichever half is still on the bus.
    assign aw_have = (w_state_q == WHaveAw) || aw_fire;
    assign w_have  = (w_state_q == WHaveW) || w_fire;
    assign commit  = aw_have && w_have;
    assign wr_addr = (w_state_q == WHaveAw) ? awaddr_q : awaddr;
    assign wr_data = (w_state_q == WHaveW) ? wdata_q : wdata;
    assign wr_strb = (w_state_q == WHaveW) ? wstrb_q : wstrb;

    assign wr_word     = wr_addr & WordMask;
    assign wr_off      = wr_word - AddrBase;
    assign wr_data_hit = (wr_word >= AddrBase) && (wr_off < AddrSpan);
    assign wr_reg_hit  = (wr_word == AddrCtrl) || (wr_word == AddrCycles) ||
                         (wr_word == AddrMemsel);
    assign wr_ok       = wr_reg_hit || (wr_data_hit && !busy);
    assign wr_idx      = wr_off[BufAw-1:0];
    assign start_d     = commit && (wr_word == AddrCtrl) && wr_strb[0] && wr_data[0];
    assign mem_we      = commit && wr_data_hit && !busy && !reset;

    assign rd_word     = araddr & WordMask;
    assign rd_off      = rd_word - AddrBase;
    assign rd_data_hit = (rd_word >= AddrBase) && (rd_off < AddrSpan);
    assign rd_idx      = rd_off[BufAw-1:0];

    // Write FSM next state
    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            WResp: begin
                if (bready) w_state_d = WIdle;
            end
            default: begin
                if (commit)       w_state_d = WResp;
                else if (aw_have) w_state_d = WHaveAw;
                else if (w_have)  w_state_d = WHaveW;
                else              w_state_d = WIdle;
            end
        endcase
    end

    // Write channel state, held halves and the register file
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_state_q <= WIdle;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= RespOkay;
            cycles_q  <= '0;
            memsel_q  <= 1'b0;
            done_q    <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            start_q   <= start_d;
            if (aw_fire) awaddr_q <= awaddr;
            if (w_fire) begin
                wdata_q <= wdata;
                wstrb_q <= wstrb;
            end
            if (commit) bresp_q <= wr_ok ? RespOkay : RespSlverr;
            if (commit && (wr_word == AddrCycles) && wr_strb[0]) cycles_q <= wr_data[7:0];
            if (commit && (wr_word == AddrMemsel) && wr_strb[0]) memsel_q <= wr_data[0];
            // A done level in the same cycle as a START write keeps the bit set.
            if (done)         done_q <= 1'b1;
            else if (start_d) done_q <= 1'b0;
        end
    end

    // Operand buffer byte writes (contents survive reset)
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int k = 0; k < 4; k++) begin
                if (wr_strb[k]) mem_q[wr_idx + BufAw'(k)] <= wr_data[8*k +: 8];
            end
        end
    end

    // Read data decode; buffer bytes are read before any same-edge write lands
    always_comb begin
        rd_value = '0;
        rd_ok    = 1'b1;
        if (rd_word == AddrCtrl) begin
            rd_value = {30'b0, done_q, 1'b0};
        end else if (rd_word == AddrCycles) begin
            rd_value = {24'b0, cycles_q};
        end else if (rd_word == AddrMemsel) begin
            rd_value = {31'b0, memsel_q};
        end else if (rd_data_hit) begin
            for (int k = 0; k < 4; k++) rd_value[8*k +: 8] = mem_q[rd_idx + BufAw'(k)];
        end else begin
            rd_ok = 1'b0;
        end
    end

    // Read FSM next state
    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            RIdle:   if (ar_fire) r_state_d = RResp;
            default: if (rready && !ar_fire) r_state_d = RIdle;
        endcase
    end

    // Read channel state and registered response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q <= RIdle;
            rdata_q   <= '0;
            rresp_q   <= RespOkay;
        end else begin
            r_state_q <= r_state_d;
            if (ar_fire) begin
                rdata_q <= rd_value;
                rresp_q <= rd_ok ? RespOkay : RespSlverr;
            end
        end
    end

    // Array-side byte read port, one cycle latency
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_rdata_q <= '0;
        end else if ({1'b0, buf_raddr} < (BufAw + 1)'(BufBytes)) begin
            buf_rdata_q <= mem_q[buf_raddr];
        end else begin
            buf_rdata_q <= '0;
        end
    end

    assign bvalid    = (w_state_q == WResp);
    assign bresp     = bresp_q;
    assign rvalid    = (r_state_q == RResp);
    assign rdata     = rdata_q;
    assign rresp     = rresp_q;
    assign start     = start_q;
    assign cycles    = cycles_q;
    assign memsel    = memsel_q;
    assign buf_rdata = buf_rdata_q;

endmodule

// File: tb/tb_mxu_axil_regs.sv
// Bench for mxu_axil_regs: directed vector table, hand sequences and a randomized model check.
module tb_mxu_axil_regs;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] awaddr = '0, araddr = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid, start, memsel;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [7:0]  cycles, buf_rdata;
    logic        done = 1'b0, busy = 1'b0;
    logic [8:0]  buf_raddr = '0;

    always #5 clk = ~clk;

    mxu_axil_regs #(.SIZE(16), .ADDR_W(16), .DATA_BASE(32'h0100)) dut (
        .clk(clk), .reset(reset),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .start(start), .done(done), .busy(busy), .cycles(cycles), .memsel(memsel),
        .buf_raddr(buf_raddr), .buf_rdata(buf_rdata)
    );

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    logic start_at_b;
    bit   done_on_commit = 1'b0;

    // Reference model state
    logic [7:0] buf_m [512];
    logic [7:0] cycles_m;
    logic       memsel_m, done_m;

    always @(negedge clk) if (start === 1'b1) start_cnt++;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: handshake timeout", name);
    endtask

    function automatic logic [1:0] model_write(input logic [15:0] a, input logic [31:0] d,
                                               input logic [3:0] s, input logic b);
        int w;
        w = int'(a) / 4 * 4;
        if (w == 0) begin
            if (s[0] && d[0]) done_m = 1'b0;
            return 2'b00;
        end
        if (w == 4) begin
            if (s[0]) cycles_m = d[7:0];
            return 2'b00;
        end
        if (w == 8) begin
            if (s[0]) memsel_m = d[0];
            return 2'b00;
        end
        if (w >= 256 && w < 256 + 512) begin
            if (b) return 2'b10;
            for (int k = 0; k < 4; k++) if (s[k]) buf_m[w - 256 + k] = d[8*k +: 8];
            return 2'b00;
        end
        return 2'b10;
    endfunction

    function automatic logic [33:0] model_read(input logic [15:0] a);
        int w;
        w = int'(a) / 4 * 4;
        if (w == 0) return {2'b00, 30'b0, done_m, 1'b0};
        if (w == 4) return {2'b00, 24'b0, cycles_m};
        if (w == 8) return {2'b00, 31'b0, memsel_m};
        if (w >= 256 && w < 256 + 512)
            return {2'b00, buf_m[w-256+3], buf_m[w-256+2], buf_m[w-256+1], buf_m[w-256]};
        return {2'b10, 32'b0};
    endfunction

    task automatic axi_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic b, output logic [1:0] resp);
        int n;
        logic aw_go, w_go;
        @(negedge clk);
        busy = b; awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b1;
        if (done_on_commit) done = 1'b1;
        n = 0;
        while ((awvalid || wvalid) && n < 20) begin
            aw_go = awvalid && awready;
            w_go  = wvalid && wready;
            @(negedge clk);
            done = 1'b0;
            if (aw_go) awvalid = 1'b0;
            if (w_go)  wvalid  = 1'b0;
            n++;
        end
        while (!bvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bvalid) begin
            timeout("axi_write");
            resp = 2'bxx;
            start_at_b = 1'bx;
        end else begin
            resp = bresp;
            start_at_b = start;
        end
        @(negedge clk);
        bready = 1'b0; busy = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic axi_read(input logic [15:0] a, input logic b, output logic [31:0] d,
                            output logic [1:0] r);
        int n;
        @(negedge clk);
        busy = b; araddr = a; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        while (!arready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        arvalid = 1'b0;
        while (!rvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rvalid) begin
            timeout("axi_read");
            d = 'x;
            r = 'x;
        end else begin
            d = rdata;
            r = rresp;
        end
        @(negedge clk);
        rready = 1'b0; busy = 1'b0;
    endtask

    typedef struct {
        bit          is_wr;
        logic [15:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic        busy;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;

    function automatic vec_t vw(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                                input logic b, input logic [1:0] r);
        return '{1'b1, a, d, s, b, r, 32'h0};
    endfunction

    function automatic vec_t vr(input logic [15:0] a, input logic b, input logic [1:0] r,
                                input logic [31:0] d);
        return '{1'b0, a, 32'h0, 4'h0, b, r, d};
    endfunction

    function automatic logic [15:0] pick_addr();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'h0004;
            2:       return 16'h0008;
            5:       return 16'($urandom_range(0, 16'hFFFF));
            default: return 16'(16'h0100 + 4 * $urandom_range(0, 127) + $urandom_range(0, 3));
        endcase
    endfunction

    vec_t        vecs[$];
    logic [1:0]  resp, rr;
    logic [31:0] rd;
    int          cnt0;

    initial begin
        vecs.push_back(vr(16'h0000, 1'b0, 2'b00, 32'h0000_0000));
        vecs.push_back(vr(16'h0004, 1'b0, 2'b00, 32'h0000_00A5));
        vecs.push_back(vw(16'h0004, 32'h1234_5677, 4'b0010, 1'b0, 2'b00));
        vecs.push_back(vr(16'h0004, 1'b0, 2'b00, 32'h0000_00A5));
        vecs.push_back(vw(16'h0008, 32'hFFFF_FFFF, 4'b0001, 1'b0, 2'b00));
        vecs.push_back(vr(16'h0008, 1'b0, 2'b00, 32'h0000_0001));
        vecs.push_back(vw(16'h0008, 32'h0000_0000, 4'b1110, 1'b0, 2'b00));
        vecs.push_back(vr(16'h0008, 1'b0, 2'b00, 32'h0000_0001));
        vecs.push_back(vw(16'h0100, 32'h0403_0201, 4'b0101, 1'b0, 2'b00));
        vecs.push_back(vr(16'h0100, 1'b0, 2'b00, 32'h0003_0001));
        vecs.push_back(vr(16'h0103, 1'b0, 2'b00, 32'h0003_0001));
        vecs.push_back(vw(16'h0104, 32'hDEAD_BEEF, 4'b1111, 1'b1, 2'b10));
        vecs.push_back(vr(16'h0104, 1'b1, 2'b00, 32'h0000_0000));
        vecs.push_back(vw(16'hFFFC, 32'h0000_0001, 4'b1111, 1'b0, 2'b10));
        vecs.push_back(vr(16'hFFFC, 1'b0, 2'b10, 32'h0000_0000));
        vecs.push_back(vw(16'h02FC, 32'hCAFE_F00D, 4'b1111, 1'b0, 2'b00));
        vecs.push_back(vr(16'h02FC, 1'b0, 2'b00, 32'hCAFE_F00D));
        vecs.push_back(vw(16'h0300, 32'h1111_1111, 4'b1111, 1'b0, 2'b10));
        vecs.push_back(vr(16'h0300, 1'b0, 2'b10, 32'h0000_0000));
        vecs.push_back(vr(16'h00FC, 1'b0, 2'b10, 32'h0000_0000));
        vecs.push_back(vw(16'h000C, 32'h0000_0001, 4'b1111, 1'b0, 2'b10));
        vecs.push_back(vr(16'h000C, 1'b0, 2'b10, 32'h0000_0000));

        // Reset values, sampled while reset is held
        repeat (3) @(negedge clk);
        check("rst_ready", {awready, wready, arready}, 3'b111);
        check("rst_valid", {bvalid, rvalid}, 2'b00);
        check("rst_resp_data", {bresp, rresp, rdata}, '0);
        check("rst_outputs", {start, cycles, memsel, buf_rdata}, '0);
        reset = 1'b0;
        cycles_m = '0; memsel_m = 1'b0; done_m = 1'b0;
        axi_read(16'h0000, 1'b0, rd, rr);
        check("rst_ctrl_read", {rr, rd}, '0);

        // W two cycles ahead of AW
        @(negedge clk);
        wdata = 32'h0000_00A5; wstrb = 4'b0001; wvalid = 1'b1;
        @(negedge clk);
        wvalid = 1'b0;
        check("w_first_held", {wready, awready, bvalid}, 3'b010);
        @(negedge clk);
        check("w_first_no_b", bvalid, 1'b0);
        awaddr = 16'h0004; awvalid = 1'b1; bready = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        check("w_first_b", {bvalid, bresp}, 3'b100);
        check("w_first_cycles", cycles, 8'hA5);
        @(negedge clk);
        check("w_first_b_done", bvalid, 1'b0);
        bready = 1'b0;
        void'(model_write(16'h0004, 32'hA5, 4'b0001, 1'b0));

        // Zero both operand buffers so every byte has a known value
        for (int i = 0; i < 128; i++) begin
            axi_write(16'(16'h0100 + 4 * i), 32'h0, 4'hF, 1'b0, resp);
            void'(model_write(16'(16'h0100 + 4 * i), 32'h0, 4'hF, 1'b0));
            check("init_bresp", resp, 2'b00);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].is_wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].busy, resp);
                void'(model_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].busy));
                check($sformatf("vec%0d_bresp", i), resp, vecs[i].resp);
            end else begin
                axi_read(vecs[i].addr, vecs[i].busy, rd, rr);
                check($sformatf("vec%0d_rresp", i), rr, vecs[i].resp);
                check($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
            end
        end
        check("vec_cycles_port", cycles, 8'hA5);
        check("vec_memsel_port", memsel, 1'b1);

        // Array byte port
        @(negedge clk) buf_raddr = 9'd0;
        @(negedge clk) check("buf_port_0", buf_rdata, 8'h01);
        buf_raddr = 9'd1;
        @(negedge clk) check("buf_port_1", buf_rdata, 8'h00);
        buf_raddr = 9'd2;
        @(negedge clk) check("buf_port_2", buf_rdata, 8'h03);
        buf_raddr = 9'd511;
        @(negedge clk) check("buf_port_511", buf_rdata, 8'hCA);

        // START pulse and sticky DONE
        cnt0 = start_cnt;
        axi_write(16'h0000, 32'h1, 4'b0001, 1'b0, resp);
        void'(model_write(16'h0000, 32'h1, 4'b0001, 1'b0));
        check("start_with_b", {resp, start_at_b}, 3'b001);
        check("start_one_cycle", start_cnt - cnt0, 1);
        cnt0 = start_cnt;
        axi_write(16'h0000, 32'h1, 4'b0010, 1'b0, resp);
        check("start_no_strb", {resp, start_at_b}, 3'b000);
        check("start_no_strb_cnt", start_cnt - cnt0, 0);
        @(negedge clk) done = 1'b1;
        @(negedge clk) done = 1'b0;
        done_m = 1'b1;
        axi_read(16'h0000, 1'b0, rd, rr);
        check("done_set", {rr, rd}, 34'h2);
        axi_write(16'h0000, 32'h1, 4'b0001, 1'b0, resp);
        void'(model_write(16'h0000, 32'h1, 4'b0001, 1'b0));
        axi_read(16'h0000, 1'b0, rd, rr);
        check("done_cleared", {rr, rd}, 34'h0);
        done_on_commit = 1'b1;
        axi_write(16'h0000, 32'h1, 4'b0001, 1'b0, resp);
        done_on_commit = 1'b0;
        done_m = 1'b1;
        axi_read(16'h0000, 1'b0, rd, rr);
        check("done_set_wins", {rr, rd}, 34'h2);

        // Write commit and read of the same word in one cycle: read sees the old value
        @(negedge clk);
        awaddr = 16'h0004; awvalid = 1'b1; wdata = 32'h11; wstrb = 4'b0001; wvalid = 1'b1;
        bready = 1'b1; araddr = 16'h0004; arvalid = 1'b1; rready = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("same_cycle_rdata", {rvalid, rdata}, {1'b1, 24'b0, cycles_m});
        check("same_cycle_write", {bvalid, cycles}, {1'b1, 8'h11});
        void'(model_write(16'h0004, 32'h11, 4'b0001, 1'b0));
        @(negedge clk);
        check("same_cycle_done", {bvalid, rvalid}, 2'b00);
        bready = 1'b0; rready = 1'b0;

        // Back-to-back reads with rready held
        @(negedge clk);
        araddr = 16'h0004; arvalid = 1'b1; rready = 1'b1;
        @(negedge clk);
        check("b2b_first", {rvalid, rdata}, {1'b1, 32'h11});
        check("b2b_arready", arready, 1'b1);
        araddr = 16'h0008;
        @(negedge clk);
        check("b2b_second", {rvalid, rdata}, {1'b1, 31'b0, memsel_m});
        arvalid = 1'b0;
        @(negedge clk);
        check("b2b_idle", rvalid, 1'b0);
        rready = 1'b0;

        // Randomized traffic against the model
        for (int i = 0; i < 250; i++) begin
            logic [15:0] a;
            logic [31:0] d;
            logic [3:0]  s;
            logic        b;
            logic [1:0]  exp_b;
            logic [33:0] exp_r;
            a = pick_addr();
            b = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                exp_b = model_write(a, d, s, b);
                axi_write(a, d, s, b, resp);
                check($sformatf("rnd_bresp@%h", a), resp, exp_b);
                check("rnd_regs", {cycles, memsel}, {cycles_m, memsel_m});
            end else begin
                exp_r = model_read(a);
                axi_read(a, b, rd, rr);
                check($sformatf("rnd_read@%h", a), {rr, rd}, exp_r);
            end
        end
        for (int i = 0; i < 16; i++) begin
            int idx;
            idx = $urandom_range(0, 511);
            @(negedge clk) buf_raddr = 9'(idx);
            @(negedge clk) check($sformatf("rnd_buf@%0d", idx), buf_rdata, buf_m[idx]);
        end

        // Stalled write response, then reset in the middle of it
        @(negedge clk);
        awaddr = 16'h0008; awvalid = 1'b1; wdata = 32'h0; wstrb = 4'b0001; wvalid = 1'b1;
        bready = 1'b0;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        void'(model_write(16'h0008, 32'h0, 4'b0001, 1'b0));
        for (int i = 0; i < 5; i++) begin
            check("hold_b", {bvalid, awready, wready}, 3'b100);
            @(negedge clk);
        end
        #2 reset = 1'b1;
        #1 check("rst_mid_b", {bvalid, awready, wready}, 3'b011);
        check("rst_mid_regs", {cycles, memsel, start}, '0);
        @(negedge clk) reset = 1'b0;
        cycles_m = '0; memsel_m = 1'b0; done_m = 1'b0;
        axi_read(16'h0000, 1'b0, rd, rr);
        check("post_rst_ctrl", {rr, rd}, 34'h0);
        axi_read(16'h02FC, 1'b0, rd, rr);
        check("post_rst_buf_kept", {rr, rd}, model_read(16'h02FC));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
